// File: rtl/jpeg_du_loader.sv
// Packs one 8x8 YUV 4:4:4 block into the 192-byte DU RAM (Y, U, V planes) and hands it to the core.
// Optional build macro JPEG_DU_LVLSHIFT_EN: write every sample level-shifted (bit 7 inverted).
module jpeg_du_loader #(
    parameter int NPIX   = 64,
    parameter int U_BASE = 64,
    parameter int V_BASE = 128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        abort,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [7:0]  pix_y,
    input  logic [7:0]  pix_u,
    input  logic [7:0]  pix_v,
    output logic [7:0]  du_ram_aw,
    output logic [7:0]  du_ram_di,
    output logic        du_ram_we,
    output logic        du_ready,
    input  logic        du_release,
    output logic [15:0] blk_cnt
);

    localparam int IDX_W = $clog2(NPIX);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);
    localparam logic [7:0] U_BASE_A = 8'(U_BASE);
    localparam logic [7:0] V_BASE_A = 8'(V_BASE);

    // Every plane must fit inside the 192-byte DU RAM.
    if ((U_BASE + NPIX > 192) || (V_BASE + NPIX > 192)) begin : g_bad_plane_base
        $error("jpeg_du_loader: U_BASE/V_BASE + NPIX exceeds DU RAM size");
    end

    typedef enum logic [2:0] {
        S_CAP,
        S_U,
        S_V,
        S_DRAIN,
        S_FULL
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [7:0]       idx_ext;
    logic             started;
    logic [7:0]       u_hold;
    logic [7:0]       v_hold;
    logic             accept;

    function automatic logic [7:0] shape_sample(input logic [7:0] s);
`ifdef JPEG_DU_LVLSHIFT_EN
        return {~s[7], s[6:0]};
`else
        return s;
`endif
    endfunction

    // pix_ready stays low for the first cycle out of reset via the started flop.
    assign pix_ready = started && (state == S_CAP);
    assign accept    = pix_valid && pix_ready;
    assign idx_ext   = 8'(idx);

    always_ff @(posedge clk) begin
        if (accept) begin
            u_hold <= pix_u;
            v_hold <= pix_v;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_CAP;
            idx       <= '0;
            started   <= 1'b0;
            du_ram_we <= 1'b0;
            du_ram_aw <= 8'd0;
            du_ram_di <= 8'd0;
            du_ready  <= 1'b0;
            blk_cnt   <= 16'd0;
        end else begin
            started <= 1'b1;
            if (abort) begin
                state     <= S_CAP;
                idx       <= '0;
                du_ram_we <= 1'b0;
                du_ready  <= 1'b0;
            end else begin
                case (state)
                    S_CAP: begin
                        if (accept) begin
                            du_ram_we <= 1'b1;
                            du_ram_aw <= idx_ext;
                            du_ram_di <= shape_sample(pix_y);
                            state     <= S_U;
                        end else begin
                            du_ram_we <= 1'b0;
                        end
                    end
                    S_U: begin
                        du_ram_we <= 1'b1;
                        du_ram_aw <= U_BASE_A + idx_ext;
                        du_ram_di <= shape_sample(u_hold);
                        state     <= S_V;
                    end
                    S_V: begin
                        du_ram_we <= 1'b1;
                        du_ram_aw <= V_BASE_A + idx_ext;
                        du_ram_di <= shape_sample(v_hold);
                        if (idx == LAST_IDX) begin
                            state <= S_DRAIN;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_CAP;
                        end
                    end
                    S_DRAIN: begin
                        du_ram_we <= 1'b0;
                        du_ready  <= 1'b1;
                        state     <= S_FULL;
                    end
                    S_FULL: begin
                        du_ram_we <= 1'b0;
                        if (du_release) begin
                            du_ready <= 1'b0;
                            idx      <= '0;
                            blk_cnt  <= blk_cnt + 16'd1;
                            state    <= S_CAP;
                        end
                    end
                    default: begin
                        du_ram_we <= 1'b0;
                        state     <= S_CAP;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jpeg_du_loader.sv
// Scoreboard bench for jpeg_du_loader: driver queues expected RAM writes, monitor checks them.
module tb_jpeg_du_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        abort = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [7:0]  pix_y = 8'd0;
    logic [7:0]  pix_u = 8'd0;
    logic [7:0]  pix_v = 8'd0;
    logic [7:0]  du_ram_aw;
    logic [7:0]  du_ram_di;
    logic        du_ram_we;
    logic        du_ready;
    logic        du_release = 1'b0;
    logic [15:0] blk_cnt;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int exp_idx = 0;
    logic [15:0] exp_q[$];

    jpeg_du_loader dut (
        .clk(clk), .reset_n(reset_n), .abort(abort),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_y(pix_y), .pix_u(pix_u), .pix_v(pix_v),
        .du_ram_aw(du_ram_aw), .du_ram_di(du_ram_di), .du_ram_we(du_ram_we),
        .du_ready(du_ready), .du_release(du_release), .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_byte(input logic [7:0] s);
`ifdef JPEG_DU_LVLSHIFT_EN
        return s ^ 8'h80;
`else
        return s;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every presented write must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && du_ram_we === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual=aw%0h/di%0h required=none", du_ram_aw, du_ram_di);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("wr_aw", 32'(du_ram_aw), 32'(e[15:8]));
                chk("wr_di", 32'(du_ram_di), 32'(e[7:0]));
            end
        end
    end

    task automatic send(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
        bit acc = 0;
        pix_y = y; pix_u = u; pix_v = v; pix_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            if (pix_ready === 1'b1) begin
                acc = 1;
                exp_q.push_back({8'(exp_idx), exp_byte(y)});
                exp_q.push_back({8'(64 + exp_idx), exp_byte(u)});
                exp_q.push_back({8'(128 + exp_idx), exp_byte(v)});
                exp_idx++;
            end
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_pat(input int p);
        send(8'(p), 8'(8'h40 + p), 8'(8'h80 + p));
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_full();
        for (int k = 0; k < 20 && du_ready !== 1'b1; k++) @(negedge clk);
        chk("du_ready_full", 32'(du_ready), 32'd1);
        chk("pix_ready_full", 32'(pix_ready), 32'd0);
    endtask

    task automatic pulse(input bit do_abort, input bit do_release);
        abort = do_abort; du_release = do_release;
        @(posedge clk);
        #1;
        abort = 1'b0; du_release = 1'b0;
    endtask

    initial begin
        int w0;
        // Reset values
        @(negedge clk);
        chk("rst_we", 32'(du_ram_we), 32'd0);
        chk("rst_aw", 32'(du_ram_aw), 32'd0);
        chk("rst_di", 32'(du_ram_di), 32'd0);
        chk("rst_du_ready", 32'(du_ready), 32'd0);
        chk("rst_blk_cnt", 32'(blk_cnt), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_pix_ready_c1", 32'(pix_ready), 32'd0);
        @(negedge clk);
        chk("rst_pix_ready_c2", 32'(pix_ready), 32'd1);
        chk("rst_we_c2", 32'(du_ram_we), 32'd0);
        @(posedge clk);
        #1;

        // Full block, pix_valid held high
        w0 = wr_cnt;
        for (int p = 0; p < 64; p++) send_pat(p);
        repeat (3) @(negedge clk);
        chk("last_we", 32'(du_ram_we), 32'd1);
        chk("last_aw", 32'(du_ram_aw), 32'd191);
        chk("last_du_ready", 32'(du_ready), 32'd0);
        @(negedge clk);
        chk("full_du_ready", 32'(du_ready), 32'd1);
        chk("full_we", 32'(du_ram_we), 32'd0);
        chk("full_pix_ready", 32'(pix_ready), 32'd0);
        chk("full_wr_count", 32'(wr_cnt - w0), 32'd192);
        pix_y = 8'hEE; pix_u = 8'hEE; pix_v = 8'hEE; pix_valid = 1'b1;
        repeat (5) @(negedge clk);
        chk("held_off", 32'(pix_ready), 32'd0);
        pix_valid = 1'b0;
        @(posedge clk);
        #1;

        // Release
        pulse(0, 1);
        @(negedge clk);
        chk("rel_du_ready", 32'(du_ready), 32'd0);
        chk("rel_blk_cnt", 32'(blk_cnt), 32'd1);
        chk("rel_pix_ready", 32'(pix_ready), 32'd1);
        exp_idx = 0;
        @(posedge clk);
        #1;
        send_pat(0);

        // Backpressure with a stray release while filling
        for (int p = 1; p < 64; p++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send_pat(p);
            if (p == 10) begin
                pulse(0, 1);
                @(negedge clk);
                chk("stray_rel_blk_cnt", 32'(blk_cnt), 32'd1);
                chk("stray_rel_du_ready", 32'(du_ready), 32'd0);
                @(posedge clk);
                #1;
            end
        end
        wait_drain();
        wait_full();
        @(posedge clk);
        #1;
        pulse(0, 1);
        @(negedge clk);
        chk("rel2_blk_cnt", 32'(blk_cnt), 32'd2);
        exp_idx = 0;
        @(posedge clk);
        #1;

        // Abort after 20 pixels, mid-write
        for (int p = 0; p < 20; p++) send_pat(p);
        pulse(1, 0);
        @(negedge clk);
        chk("abort_we", 32'(du_ram_we), 32'd0);
        chk("abort_du_ready", 32'(du_ready), 32'd0);
        chk("abort_pix_ready", 32'(pix_ready), 32'd1);
        chk("abort_blk_cnt", 32'(blk_cnt), 32'd2);
        exp_q.delete();
        exp_idx = 0;
        @(posedge clk);
        #1;
        send(8'h00, 8'hFF, 8'h80);
        send(8'hFF, 8'h80, 8'h00);
        send(8'h80, 8'h00, 8'hFF);
        for (int p = 3; p < 64; p++) send_pat(p);
        wait_drain();
        wait_full();
        @(posedge clk);
        #1;

        // Abort together with release from a full block
        pulse(1, 1);
        @(negedge clk);
        chk("abrel_blk_cnt", 32'(blk_cnt), 32'd2);
        chk("abrel_du_ready", 32'(du_ready), 32'd0);
        chk("abrel_pix_ready", 32'(pix_ready), 32'd1);
        exp_idx = 0;
        @(posedge clk);
        #1;
        send(8'h12, 8'h34, 8'h56);
        wait_drain();
        @(posedge clk);
        #1;

        // Asynchronous reset mid-block
        send_pat(1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_we", 32'(du_ram_we), 32'd0);
        chk("arst_aw", 32'(du_ram_aw), 32'd0);
        chk("arst_blk_cnt", 32'(blk_cnt), 32'd0);
        chk("arst_pix_ready", 32'(pix_ready), 32'd0);
        exp_q.delete();
        exp_idx = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        send_pat(7);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
